mem_access_ctrl: RTL and testbench

// - Initiator for the unified 32-bit instruction/data memory (sync, 1-cycle read latency, we/re strobes).
// - Arbitrates the CPU instruction-fetch (IF) port and load/store (LS) port onto the single memory port.
// - Sequences one access at a time and returns read data or a write acknowledgement to the requesting port.

---
 rtl/mem_access_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Single-port memory initiator: arbitrates IF fetches and LS loads/stores, one access at a time.
// Optional address range check enabled by defining MEMCTL_ADDR_CHECK_EN.
module mem_access_ctrl #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_DEPTH = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_rsp_valid,
   output logic [DATA_W-1:0] if_rsp_data,
   input  logic              ls_req_valid,
   output logic              ls_req_ready,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_rsp_valid,
   output logic [DATA_W-1:0] ls_rsp_data,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_data_out
);

`ifdef MEMCTL_ADDR_CHECK_EN
   localparam bit ADDR_CHECK = 1'b1;
`else
   localparam bit ADDR_CHECK = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state;
   logic              we_q;
   logic              src_ls_q;
   logic              err_q;
   logic [DATA_W-1:0] rd_q;

   logic              accept_c;
   logic              sel_ls_c;
   logic              sel_we_c;
   logic              sel_err_c;
   logic [ADDR_W-1:0] sel_addr_c;
   logic [DATA_W-1:0] sel_wdata_c;

   // Fixed LS priority; readies are only ever high in IDLE
   assign ls_req_ready = (state == S_IDLE);
   assign if_req_ready = (state == S_IDLE) && !ls_req_valid;

   // Request selection for the accept cycle
   always_comb begin
      accept_c    = 1'b0;
      sel_ls_c    = 1'b0;
      sel_we_c    = 1'b0;
      sel_addr_c  = if_addr;
      sel_wdata_c = '0;
      sel_err_c   = 1'b0;
      if (state == S_IDLE) begin
         accept_c = ls_req_valid || if_req_valid;
      end
      if (ls_req_valid) begin
         sel_ls_c    = 1'b1;
         sel_we_c    = ls_we;
         sel_addr_c  = ls_addr;
         sel_wdata_c = ls_wdata;
      end
      sel_err_c = ADDR_CHECK && (32'(sel_addr_c) >= MEM_DEPTH);
   end

   // Sequencer: all memory strobes and responses are registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         we_q         <= 1'b0;
         src_ls_q     <= 1'b0;
         err_q        <= 1'b0;
         rd_q         <= '0;
         mem_addr     <= '0;
         mem_data_in  <= '0;
         mem_we       <= 1'b0;
         mem_re       <= 1'b0;
         if_rsp_valid <= 1'b0;
         if_rsp_data  <= '0;
         ls_rsp_valid <= 1'b0;
         ls_rsp_data  <= '0;
         rsp_err      <= 1'b0;
      end else begin
         mem_we       <= 1'b0;
         mem_re       <= 1'b0;
         if_rsp_valid <= 1'b0;
         ls_rsp_valid <= 1'b0;
         rsp_err      <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept_c) begin
                  we_q     <= sel_we_c;
                  src_ls_q <= sel_ls_c;
                  err_q    <= sel_err_c;
                  if (sel_err_c) begin
                     state <= S_DONE;
                  end else begin
                     state       <= S_ISSUE;
                     mem_addr    <= sel_addr_c;
                     mem_data_in <= sel_wdata_c;
                     mem_we      <= sel_we_c;
                     mem_re      <= !sel_we_c;
                  end
               end
            end
            S_ISSUE: begin
               state <= we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
               rd_q  <= mem_data_out;
               state <= S_DONE;
            end
            S_DONE: begin
               state   <= S_IDLE;
               rsp_err <= err_q;
               if (src_ls_q) begin
                  ls_rsp_valid <= 1'b1;
                  ls_rsp_data  <= (we_q || err_q) ? '0 : rd_q;
               end else begin
                  if_rsp_valid <= 1'b1;
                  if_rsp_data  <= err_q ? '0 : rd_q;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 1-cycle-latency synchronous memory model.
module tb_mem_access_ctrl;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;

   logic              clk;
   logic              rst;
   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_addr;
   logic              if_rsp_valid;
   logic [DATA_W-1:0] if_rsp_data;
   logic              ls_req_valid;
   logic              ls_req_ready;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_rsp_valid;
   logic [DATA_W-1:0] ls_rsp_data;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_data_out;

   logic [DATA_W-1:0] mem [0:4095];
   int n_vec;
   int n_err;
   int re_cnt;
   int we_cnt;
   int rsp_cnt;
   int viol_cnt;

   mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(4096)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .if_addr      (if_addr),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_data  (if_rsp_data),
      .ls_req_valid (ls_req_valid),
      .ls_req_ready (ls_req_ready),
      .ls_we        (ls_we),
      .ls_addr      (ls_addr),
      .ls_wdata     (ls_wdata),
      .ls_rsp_valid (ls_rsp_valid),
      .ls_rsp_data  (ls_rsp_data),
      .rsp_err      (rsp_err),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_we       (mem_we),
      .mem_re       (mem_re),
      .mem_data_out (mem_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model plus strobe/response bookkeeping
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[11:0]] <= mem_data_in;
      if (mem_re) mem_data_out <= mem[mem_addr[11:0]];
      if (mem_re) re_cnt <= re_cnt + 1;
      if (mem_we) we_cnt <= we_cnt + 1;
      if (if_rsp_valid || ls_rsp_valid) rsp_cnt <= rsp_cnt + 1;
      if ((mem_we && mem_re) || (if_rsp_valid && ls_rsp_valid)) viol_cnt <= viol_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one request at a negedge and check strobes, latency, data and error flag
   task automatic run_req(input string tag, input bit is_ls, input bit we,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input bit exp_issue, input int exp_lat,
                          input logic [DATA_W-1:0] exp_data, input bit exp_err);
      int n;
      int re0;
      int we0;
      if (is_ls) begin
         ls_req_valid = 1'b1; ls_we = we; ls_addr = a; ls_wdata = d;
      end else begin
         if_req_valid = 1'b1; if_addr = a;
      end
      n = 0;
      while (!(is_ls ? ls_req_ready : if_req_ready) && n < 20) begin
         @(negedge clk); n++;
      end
      chk({tag, "_ready_wait"}, 32'(n < 20), 32'd1);
      re0 = re_cnt;
      we0 = we_cnt;
      @(posedge clk);
      @(negedge clk);
      ls_req_valid = 1'b0; if_req_valid = 1'b0;
      ls_we = ~we; ls_addr = 16'hBAD0; if_addr = 16'hBAD1; ls_wdata = 32'h5555AAAA;
      if (exp_issue) begin
         chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(a));
         chk({tag, "_strobes"}, {30'd0, mem_we, mem_re}, {30'd0, we, !we});
      end else begin
         chk({tag, "_strobes_idle"}, {30'd0, mem_we, mem_re}, 32'd0);
      end
      n = 0;
      while (!(is_ls ? ls_rsp_valid : if_rsp_valid) && n < 12) begin
         @(negedge clk); n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_data"}, is_ls ? ls_rsp_data : if_rsp_data, exp_data);
      chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, "_pulses"}, 32'((re_cnt - re0) * 16 + (we_cnt - we0)),
          32'(exp_issue ? (we ? 1 : 16) : 0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int rsp0;
      n_vec = 0; n_err = 0;
      re_cnt = 0; we_cnt = 0; rsp_cnt = 0; viol_cnt = 0;
      for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
      mem[0]  = 32'h02001400;
      mem[1]  = 32'h02001501;
      mem[20] = 32'h00000010;
      mem_data_out = '0;
      rst = 1'b1;
      if_req_valid = 1'b0; if_addr = '0;
      ls_req_valid = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_readies", {30'd0, if_req_ready, ls_req_ready}, 32'd3);
      chk("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
      chk("rst_rsp_valid", {29'd0, if_rsp_valid, ls_rsp_valid, rsp_err}, 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_data_in", mem_data_in, 32'd0);
      chk("rst_rsp_data", if_rsp_data | ls_rsp_data, 32'd0);

      // IF fetch, then LS store/load round trip
      run_req("if_rd0", 1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 3, 32'h02001400, 1'b0);
      run_req("ls_st19", 1'b1, 1'b1, 16'd19, 32'hDEADBEEF, 1'b1, 2, 32'h0, 1'b0);
      chk("st19_mem", mem[19], 32'hDEADBEEF);
      chk("if_data_held", if_rsp_data, 32'h02001400);
      run_req("ls_ld19", 1'b1, 1'b0, 16'd19, 32'd0, 1'b1, 3, 32'hDEADBEEF, 1'b0);

      // Simultaneous IF and LS: LS wins, IF follows
      if_req_valid = 1'b1; if_addr = 16'd1;
      ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 16'd20;
      #1;
      chk("arb_readies", {30'd0, if_req_ready, ls_req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      ls_req_valid = 1'b0; ls_addr = 16'hBAD0;
      chk("arb_if_blocked", 32'(if_req_ready), 32'd0);
      n = 0;
      while (!ls_rsp_valid && n < 12) begin
         @(negedge clk); n++;
      end
      chk("arb_ls_latency", 32'(n), 32'd3);
      chk("arb_ls_data", ls_rsp_data, 32'h00000010);
      chk("arb_if_not_yet", 32'(if_rsp_valid), 32'd0);
      chk("arb_if_ready_now", 32'(if_req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if_req_valid = 1'b0; if_addr = 16'hBAD1;
      n = 0;
      while (!if_rsp_valid && n < 12) begin
         @(negedge clk); n++;
      end
      chk("arb_if_latency", 32'(n), 32'd3);
      chk("arb_if_data", if_rsp_data, 32'h02001501);
      chk("ls_data_held", ls_rsp_data, 32'h00000010);

      // Reset while in WAIT drops the access
      @(negedge clk);
      if_req_valid = 1'b1; if_addr = 16'd0;
      @(posedge clk);
      @(negedge clk);
      if_req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      rsp0 = rsp_cnt;
      @(negedge clk);
      rst = 1'b0;
      chk("wrst_readies", {30'd0, if_req_ready, ls_req_ready}, 32'd3);
      chk("wrst_outputs", {28'd0, mem_we, mem_re, if_rsp_valid, ls_rsp_valid}, 32'd0);
      chk("wrst_rsp_data", if_rsp_data | ls_rsp_data | mem_data_in | 32'(mem_addr), 32'd0);
      repeat (4) @(negedge clk);
      chk("wrst_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
      run_req("post_rst_if1", 1'b0, 1'b0, 16'd1, 32'd0, 1'b1, 3, 32'h02001501, 1'b0);

      // Out-of-range address
`ifdef MEMCTL_ADDR_CHECK_EN
      run_req("ls_oor", 1'b1, 1'b0, 16'h1000, 32'd0, 1'b0, 1, 32'h0, 1'b1);
`else
      run_req("ls_oor", 1'b1, 1'b0, 16'h1000, 32'd0, 1'b1, 3, 32'h02001400, 1'b0);
`endif

      repeat (2) @(negedge clk);
      chk("mutex_violations", 32'(viol_cnt), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
